demux2_stream_gl: RTL and testbench

- Registered 1-to-2 stream demultiplexer; the distribution counterpart to the 2:1 select muxes in the datapath.
- Accepts one val/rdy message stream plus a per-message select bit, and steers each message to output port 0 or port 1.
- A single holding register sits between input and outputs, giving one cycle of latency and full throughput.
- Sits between a response source (e.g. memory or ALU result path) and two consumers; keeps a per-port delivery count for debug and verification.

---
 rtl/demux2_stream_gl.sv | 82 ++++++++
 tb/tb_demux2_stream_gl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux2_stream_gl.sv
// Registered 1-to-2 val/rdy stream demultiplexer with per-port delivery counters.
// One holding register gives one cycle of latency at full throughput.
module demux2_stream_gl #(
  parameter int unsigned nbits = 32,
  parameter int unsigned cbits = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [nbits-1:0] in_msg,
  input  logic             in_sel,
  output logic             out0_val,
  input  logic             out0_rdy,
  output logic [nbits-1:0] out0_msg,
  output logic             out1_val,
  input  logic             out1_rdy,
  output logic [nbits-1:0] out1_msg,
  input  logic             cnt_clr,
  output logic [cbits-1:0] cnt0,
  output logic [cbits-1:0] cnt1
);

  typedef enum logic [1:0] {StEmpty, StFull0, StFull1} state_e;

  state_e           state_q, state_d;
  logic [nbits-1:0] hold_q, hold_d;
  logic [cbits-1:0] cnt0_q, cnt0_d;
  logic [cbits-1:0] cnt1_q, cnt1_d;
  logic             in_fire, out0_fire, out1_fire;

  // in_rdy looks only at state and the held message's own port rdy, never at in_val.
  always_comb begin
    out0_val  = (state_q == StFull0);
    out1_val  = (state_q == StFull1);
    out0_msg  = hold_q;
    out1_msg  = hold_q;
    in_rdy    = (state_q == StEmpty) | (out0_val & out0_rdy) | (out1_val & out1_rdy);
    in_fire   = in_val & in_rdy;
    out0_fire = out0_val & out0_rdy;
    out1_fire = out1_val & out1_rdy;
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (in_fire) begin
      hold_d  = in_msg;
      state_d = in_sel ? StFull1 : StFull0;
    end else if (out0_fire || out1_fire) begin
      state_d = StEmpty;
    end
  end

  // Clear wins over a same-cycle increment.
  always_comb begin
    cnt0_d = cnt0_q + cbits'(out0_fire);
    cnt1_d = cnt1_q + cbits'(out1_fire);
    if (cnt_clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      hold_q  <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;

endmodule

// File: tb/tb_demux2_stream_gl.sv
// Self-checking bench for demux2_stream_gl: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_demux2_stream_gl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_val, in_rdy, in_sel;
  logic [31:0] in_msg;
  logic        out0_val, out0_rdy, out1_val, out1_rdy;
  logic [31:0] out0_msg, out1_msg;
  logic        cnt_clr;
  logic [7:0]  cnt0, cnt1;

  demux2_stream_gl #(.nbits(32), .cbits(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_msg   (in_msg),
    .in_sel   (in_sel),
    .out0_val (out0_val),
    .out0_rdy (out0_rdy),
    .out0_msg (out0_msg),
    .out1_val (out1_val),
    .out1_rdy (out1_rdy),
    .out1_msg (out1_msg),
    .cnt_clr  (cnt_clr),
    .cnt0     (cnt0),
    .cnt1     (cnt1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic [31:0] msg;
  } item_t;

  item_t       slot[$];   // message currently held by the block (0 or 1 entries)
  logic [31:0] sent0[$];  // accepted for port 0, not yet delivered
  logic [31:0] sent1[$];
  int          m_cnt0, m_cnt1;
  int          total, bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    slot.delete();
    sent0.delete();
    sent1.delete();
    m_cnt0 = 0;
    m_cnt1 = 0;
  endtask

  // Called just after a posedge with inputs set; checks outputs and advances one edge.
  task automatic cycle();
    logic        full, hport, exp_rdy, f0, f1, fin, sel_s, clr_s;
    logic [31:0] hmsg, msg_s, o0, o1, exp_msg;
    #1;
    full  = (slot.size() != 0);
    hport = full ? slot[0].port : 1'b0;
    hmsg  = full ? slot[0].msg : 32'h0;
    exp_rdy = !full || (hport ? out1_rdy : out0_rdy);
    check("out0_val", {31'b0, out0_val}, {31'b0, full && !hport});
    check("out1_val", {31'b0, out1_val}, {31'b0, full && hport});
    if (full) begin
      check("out0_msg", out0_msg, hmsg);
      check("out1_msg", out1_msg, hmsg);
    end
    check("in_rdy", {31'b0, in_rdy}, {31'b0, exp_rdy});
    check("cnt0", {24'b0, cnt0}, m_cnt0);
    check("cnt1", {24'b0, cnt1}, m_cnt1);
    f0    = full && !hport && out0_rdy;
    f1    = full && hport && out1_rdy;
    fin   = in_val && exp_rdy;
    sel_s = in_sel;
    msg_s = in_msg;
    clr_s = cnt_clr;
    o0    = out0_msg;
    o1    = out1_msg;
    @(posedge clk);
    if (f0 || f1) void'(slot.pop_front());
    if (f0) begin
      exp_msg = (sent0.size() != 0) ? sent0.pop_front() : 32'hxxxx_xxxx;
      check("order0", o0, exp_msg);
    end
    if (f1) begin
      exp_msg = (sent1.size() != 0) ? sent1.pop_front() : 32'hxxxx_xxxx;
      check("order1", o1, exp_msg);
    end
    if (clr_s) begin
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else begin
      if (f0) m_cnt0 = (m_cnt0 + 1) % 256;
      if (f1) m_cnt1 = (m_cnt1 + 1) % 256;
    end
    if (fin) begin
      slot.push_back('{port: sel_s, msg: msg_s});
      if (sel_s) sent1.push_back(msg_s);
      else       sent0.push_back(msg_s);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] m);
    in_val = v;
    in_sel = s;
    in_msg = m;
  endtask

  task automatic clear_counters();
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_clear();
    rst_n = 1'b0; cnt_clr = 1'b0; out0_rdy = 1'b0; out1_rdy = 1'b0;
    drive(1'b1, 1'b1, 32'h1234_5678);

    // Reset held with in_val high
    repeat (2) @(posedge clk);
    #1;
    check("rst_out0_val", {31'b0, out0_val}, 32'd0);
    check("rst_out1_val", {31'b0, out1_val}, 32'd0);
    check("rst_cnt0", {24'b0, cnt0}, 32'd0);
    check("rst_cnt1", {24'b0, cnt1}, 32'd0);
    drive(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_rdy", {31'b0, in_rdy}, 32'd1);

    // Single message to port 1
    out1_rdy = 1'b1;
    drive(1'b1, 1'b1, 32'hDEAD_BEEF);
    cycle();
    drive(1'b0, 1'b0, 32'h0);
    check("single_val1", {31'b0, out1_val}, 32'd1);
    check("single_val0", {31'b0, out0_val}, 32'd0);
    check("single_msg", out1_msg, 32'hDEAD_BEEF);
    cycle();
    check("single_cnt1", {24'b0, cnt1}, 32'd1);

    // Back-to-back throughput, alternating ports
    clear_counters();
    out0_rdy = 1'b1; out1_rdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'((i - 1) % 2), 32'(i));
      cycle();
      check("tput_val", {31'b0, ((i % 2) == 1) ? out0_val : out1_val}, 32'd1);
    end
    drive(1'b0, 1'b0, 32'h0);
    cycle();
    check("tput_cnt0", {24'b0, cnt0}, 32'd2);
    check("tput_cnt1", {24'b0, cnt1}, 32'd2);

    // Backpressure: port 0 stalled, port 1 message pending behind it
    out0_rdy = 1'b0; out1_rdy = 1'b1;
    drive(1'b1, 1'b0, 32'h0000_00A5);
    cycle();
    drive(1'b1, 1'b1, 32'h0000_0077);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_rdy", {31'b0, in_rdy}, 32'd0);
      check("bp_msg", out0_msg, 32'h0000_00A5);
      cycle();
    end
    out0_rdy = 1'b1;
    cycle();
    drive(1'b0, 1'b0, 32'h0);
    check("bp_next_val", {31'b0, out1_val}, 32'd1);
    check("bp_next_msg", out1_msg, 32'h0000_0077);
    cycle();

    // Counter wrap on port 0
    clear_counters();
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b0, 32'(i));
      cycle();
    end
    drive(1'b0, 1'b0, 32'h0);
    cycle();
    check("wrap_cnt0", {24'b0, cnt0}, 32'd0);

    // Clear beats a same-cycle increment
    clear_counters();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 32'h100 + 32'(i));
      cycle();
    end
    drive(1'b0, 1'b0, 32'h0);
    check("pre_clr_cnt1", {24'b0, cnt1}, 32'd5);
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    check("clr_prio_cnt1", {24'b0, cnt1}, 32'd0);

    // Asynchronous reset while holding a port 1 message
    out1_rdy = 1'b0;
    drive(1'b1, 1'b1, 32'hCAFE_0001);
    cycle();
    drive(1'b0, 1'b0, 32'h0);
    check("pre_arst_val1", {31'b0, out1_val}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_val1", {31'b0, out1_val}, 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom);
      out0_rdy = 1'($urandom_range(0, 3) != 0);
      out1_rdy = 1'($urandom_range(0, 2) != 0);
      cnt_clr  = ($urandom_range(0, 499) == 0);
      cycle();
    end
    drive(1'b0, 1'b0, 32'h0);
    cnt_clr = 1'b0; out0_rdy = 1'b1; out1_rdy = 1'b1;
    cycle();
    cycle();
    check("drain_sent0", sent0.size(), 32'd0);
    check("drain_sent1", sent1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
